// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_pkg
// Description : Shared types, widths and Hamming(7,4) helpers for the ECC
//               memory controller. Optional macro: ECC_WRITEBACK_EN adds
//               the scrub-writeback state.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_pkg;

   localparam int c_DATA_W = 4;
   localparam int c_CODE_W = 7;
   localparam int c_SYN_W  = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      DEC  = 3'd2,
`ifdef ECC_WRITEBACK_EN
      RSP  = 3'd3,
      WB   = 3'd4
`else
      RSP  = 3'd3
`endif
   } state_t;

   // Parity bits sit at Hamming positions 1, 2 and 4 (c0, c1, c3).
   function automatic logic [c_CODE_W-1:0] ecc_encode(input logic [c_DATA_W-1:0] d);
      logic [c_CODE_W-1:0] c;
      c[0] = d[0] ^ d[1] ^ d[3];
      c[1] = d[0] ^ d[2] ^ d[3];
      c[2] = d[0];
      c[3] = d[1] ^ d[2] ^ d[3];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      return c;
   endfunction

   function automatic logic [c_SYN_W-1:0] ecc_syndrome(input logic [c_CODE_W-1:0] c);
      logic [c_SYN_W-1:0] s;
      s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
      s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
      s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
      return s;
   endfunction

   // A nonzero syndrome names the 1-based bit position to flip; a double
   // error therefore lands on a wrong bit, which is accepted behaviour.
   function automatic logic [c_CODE_W-1:0] ecc_correct(input logic [c_CODE_W-1:0] c,
                                                        input logic [c_SYN_W-1:0]  s);
      logic [c_CODE_W-1:0] f;
      f = c;
      for (int i = 0; i < c_CODE_W; i++) begin
         if (int'(s) == i + 1) begin
            f[i] = ~c[i];
         end
      end
      return f;
   endfunction

   function automatic logic [c_DATA_W-1:0] ecc_data(input logic [c_CODE_W-1:0] c);
      return {c[6], c[5], c[4], c[2]};
   endfunction

endpackage : ecc_pkg
`default_nettype wire

// File: rtl/ecc_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : ecc_mem_array
// Description : DEPTH x CODE_W codeword storage, one synchronous write port
//               and one synchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_mem_array #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int CODE_W = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [CODE_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [CODE_W-1:0] rdata
);

   logic [CODE_W-1:0] r_mem [DEPTH];

   // Storage write and registered read; no reset so the array survives rst.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= r_mem[raddr];
      end
   end

endmodule : ecc_mem_array
`default_nettype wire

// File: rtl/ecc_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ecc_mem_ctrl
// Description : Single-request Hamming(7,4) protected memory controller with
//               fault injection, corrected read responses and a saturating
//               error counter. Optional macro: ECC_WRITEBACK_EN enables a
//               one-cycle scrub writeback after an erroneous read.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_mem_ctrl
   import ecc_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [3:0]        req_wdata,
   input  logic [6:0]        req_inj,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [3:0]        rsp_rdata,
   output logic              rsp_err,
   output logic [2:0]        rsp_syndrome,
   output logic [7:0]        err_count
);

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_W-1:0]     r_addr;
   logic                  w_mem_we;
   logic                  w_mem_re;
   logic [ADDR_W-1:0]     w_mem_waddr;
   logic [c_CODE_W-1:0]   w_mem_wdata;
   logic [c_CODE_W-1:0]   w_rd_code;
   logic [c_SYN_W-1:0]    w_syn;
   logic [c_CODE_W-1:0]   w_fixed;
`ifdef ECC_WRITEBACK_EN
   logic [c_CODE_W-1:0]   r_fix_code;
`endif

   assign w_syn   = ecc_syndrome(w_rd_code);
   assign w_fixed = ecc_correct(w_rd_code, w_syn);

   ecc_mem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .CODE_W (c_CODE_W)
   ) u_array (
      .clk   (clk),
      .we    (w_mem_we),
      .waddr (w_mem_waddr),
      .wdata (w_mem_wdata),
      .re    (w_mem_re),
      .raddr (r_addr),
      .rdata (w_rd_code)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state, handshakes and array port control.
   always_comb begin
      w_next      = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
      w_mem_waddr = req_addr;
      w_mem_wdata = ecc_encode(req_wdata) ^ req_inj;
      case (r_state)
         IDLE: begin
            req_ready = ~rst;
            if (req_valid && !rst) begin
               if (req_we) begin
                  w_mem_we = 1'b1;
               end else begin
                  w_next = RD;
               end
            end
         end
         RD: begin
            w_mem_re = 1'b1;
            w_next   = DEC;
         end
         DEC: begin
            w_next = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
`ifdef ECC_WRITEBACK_EN
               w_next = rsp_err ? WB : IDLE;
`else
               w_next = IDLE;
`endif
            end
         end
`ifdef ECC_WRITEBACK_EN
         WB: begin
            // Whole-word write gated by rst: an abort leaves the old word.
            w_mem_we    = ~rst;
            w_mem_waddr = r_addr;
            w_mem_wdata = r_fix_code;
            w_next      = IDLE;
         end
`endif
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Read address capture, decode result registers and error counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr       <= '0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         rsp_syndrome <= '0;
         err_count    <= '0;
`ifdef ECC_WRITEBACK_EN
         r_fix_code   <= '0;
`endif
      end else begin
         if (r_state == IDLE && req_valid && !req_we) begin
            r_addr <= req_addr;
         end
         if (r_state == DEC) begin
            rsp_rdata    <= ecc_data(w_fixed);
            rsp_err      <= |w_syn;
            rsp_syndrome <= w_syn;
`ifdef ECC_WRITEBACK_EN
            r_fix_code   <= w_fixed;
`endif
            if ((|w_syn) && (err_count != 8'hFF)) begin
               err_count <= err_count + 8'd1;
            end
         end
      end
   end

endmodule : ecc_mem_ctrl
`default_nettype wire

// File: tb/tb_ecc_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecc_mem_ctrl
// Description : Scoreboard bench for ecc_mem_ctrl. Expected responses come
//               from a Hamming position-XOR model of the stored codewords.
//               Honours ECC_WRITEBACK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_mem_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [3:0] req_addr = '0;
   logic [3:0] req_wdata = '0;
   logic [6:0] req_inj = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_rdata;
   logic       rsp_err;
   logic [2:0] rsp_syndrome;
   logic [7:0] err_count;

   int         n_checks = 0;
   int         n_errors = 0;
   int         exp_cnt  = 0;
   logic [7:0] sb_q [$];
   logic [6:0] model_mem [16];

   ecc_mem_ctrl #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_inj      (req_inj),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .rsp_syndrome (rsp_syndrome),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Codeword bit p-1 is Hamming position p; parity makes the XOR of all
   // set positions zero, so the syndrome is the XOR of set positions.
   function automatic logic [6:0] m_encode(input logic [3:0] d);
      logic [6:0] c;
      int x;
      c = '0;
      c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
      x = 0;
      for (int p = 1; p <= 7; p++) if (c[p-1]) x = x ^ p;
      c[0] = x[0]; c[1] = x[1]; c[3] = x[2];
      return c;
   endfunction

   function automatic int m_syn(input logic [6:0] c);
      int x;
      x = 0;
      for (int p = 1; p <= 7; p++) if (c[p-1]) x = x ^ p;
      return x;
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_wait", req_ready, 1);
   endtask

   task automatic do_write(input int a, input logic [3:0] d, input logic [6:0] inj);
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_addr = a[3:0]; req_wdata = d; req_inj = inj;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0;
      model_mem[a] = m_encode(d) ^ inj;
   endtask

   task automatic do_read(input int a, input bit hold);
      logic [6:0] c;
      logic [7:0] e;
      logic [3:0] d;
      int         s;
      int         k;
      wait_ready();
      c = model_mem[a];
      s = m_syn(c);
      if (s != 0) c[s-1] = ~c[s-1];
      d = {c[6], c[5], c[4], c[2]};
      sb_q.push_back({(s != 0), s[2:0], d});
      if (s != 0 && exp_cnt < 255) exp_cnt++;
      req_valid = 1'b1; req_we = 1'b0; req_addr = a[3:0]; rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      k = 0;
      while (!rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("rsp_latency", k, 2);
      e = sb_q.pop_front();
      if (hold) begin
         repeat (5) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 4'h0; req_inj = '0;
            @(negedge clk);
            check("hold_data", {rsp_valid, rsp_err, rsp_syndrome, rsp_rdata}, {1'b1, e});
            check("hold_req_ready", req_ready, 0);
         end
      end
      check("rsp_rdata", rsp_rdata, e[3:0]);
      check("rsp_syndrome", rsp_syndrome, e[6:4]);
      check("rsp_err", rsp_err, e[7]);
      check("err_count", err_count, exp_cnt);
      rsp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_drop", rsp_valid, 0);
`ifdef ECC_WRITEBACK_EN
      if (e[7]) model_mem[a] = c;
`endif
   endtask

   initial begin
      logic [6:0] one;
      one = 7'b1;
      repeat (2) @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_err", rsp_err, 0);
      check("rst_syndrome", rsp_syndrome, 0);
      check("rst_err_count", err_count, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", req_ready, 1);

      // Clean word, then single-bit fault at position 5, then re-read.
      do_write(3, 4'hB, 7'b0000000);
      do_read(3, 0);
      do_write(7, 4'h5, 7'b0010000);
      do_read(7, 0);
      do_read(7, 0);

      // Single-bit faults at each position across several data values.
      for (int i = 0; i < 8; i++) begin
         do_write(8 + i, 4'(i * 5 + 2), (i == 7) ? 7'b0 : (one << i));
         do_read(8 + i, 0);
      end

      // Double-bit fault is miscorrected but still flagged.
      do_write(9, 4'h9, 7'b0000011);
      do_read(9, 0);

      // Stalled response: outputs stable, concurrent write ignored.
      do_read(3, 1);
      do_read(3, 0);

      // Reset while in DEC aborts the read and clears the counter.
      do_write(7, 4'h6, 7'b1000000);
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_req_ready", req_ready, 0);
      check("abort_err_count", err_count, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      repeat (4) begin
         @(negedge clk);
         check("abort_no_rsp", rsp_valid, 0);
      end
      do_read(3, 0);

      // Saturation: 256 erroneous reads leave the counter at 255.
      for (int i = 0; i < 256; i++) begin
         do_write(5, 4'(i), one << (i % 7));
         do_read(5, 0);
      end
      check("err_count_sat", err_count, 8'd255);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_ecc_mem_ctrl
`default_nettype wire

// File: doc/ecc_mem_ctrl.md
ECC_MEM_CTRL -- requirements
Module: ecc_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of stored codewords.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH == 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  word address.
REQ-009 SHALL have port req_wdata  input  4  write data nibble.
REQ-010 SHALL have port req_inj  input  7  fault-injection mask XORed into the stored codeword on write.
REQ-011 SHALL have port rsp_valid  output  1  read response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 SHALL have port rsp_rdata  output  4  corrected read data.
REQ-014 SHALL have port rsp_err  output  1  nonzero syndrome on this read.
REQ-015 SHALL have port rsp_syndrome  output  3  raw syndrome of this read.
REQ-016 SHALL have port err_count  output  8  saturating count of reads with rsp_err.

Function
REQ-017 Encode SHALL be: c0=d0^d1^d3, c1=d0^d2^d3, c2=d0, c3=d1^d2^d3, c4=d1, c5=d2, c6=d3; stored word = c ^ req_inj.
REQ-018 Syndrome SHALL be s0=c0^c2^c4^c6, s1=c1^c2^c5^c6, s2=c3^c4^c5^c6; nonzero s flips bit c[s-1]; data = {c6,c5,c4,c2} of corrected word.
REQ-019 FSM states SHALL be IDLE, RD, DEC, RSP, WB; req_ready = 1 only in IDLE and not in reset.
REQ-020 Write accepted in IDLE SHALL update memory at that edge, produce no response, FSM stays IDLE.
REQ-021 Read accepted at edge T: IDLE->RD; RD (synchronous array read) ->DEC at T+1; DEC registers decode results, ->RSP, rsp_valid high from T+2.
REQ-022 In RSP, rsp_rdata/rsp_err/rsp_syndrome SHALL hold stable until rsp_ready; on handshake ->IDLE (or WB per REQ-029).
REQ-023 err_count SHALL increment once per read, on the DEC->RSP transition when syndrome nonzero, saturating at 255.
REQ-024 Double-bit errors SHALL be miscorrected as single-bit (no detection); rsp_err still high.
REQ-025 Read of a never-written address SHALL return undefined data; no other effect.

Reset
REQ-026 On rst: state IDLE, req_ready 0 during rst then 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, rsp_syndrome 0, err_count 0.
REQ-027 rst mid-read or mid-WB SHALL abort the operation with no response; memory array SHALL not be cleared and an aborted WB SHALL leave the word either old or corrected, never partial.

Configuration
REQ-028 Macro ECC_WRITEBACK_EN SHALL control scrub writeback.
REQ-029 With ECC_WRITEBACK_EN: after RSP handshake with rsp_err=1, FSM SHALL enter WB for one cycle writing the corrected codeword to the same address, then IDLE; req_ready 0 in WB.
REQ-030 Without ECC_WRITEBACK_EN: WB state SHALL not exist; RSP always returns to IDLE; memory only written by requests.

Structure
REQ-031 Package ecc_pkg SHALL hold the FSM state enum, codeword width 7, data width 4, and encode/syndrome functions.
REQ-032 Storage SHALL be sub-module ecc_mem_array (DEPTH x 7, one sync write, one sync read port).

Verification
REQ-033 Write 0xB addr 3 inj 0, read addr 3 -> rsp_valid 2 cycles after accept, rdata 0xB, err 0, syndrome 0.
REQ-034 Write 0x5 addr 7 inj 7'b0010000, read -> rdata 0x5, err 1, syndrome 3'b101, err_count 1.
REQ-035 With ECC_WRITEBACK_EN, repeat REQ-034 then re-read addr 7 -> err 0, err_count stays 1; without macro -> err 1, err_count 2.
REQ-036 Hold rsp_ready 0 for 5 cycles -> rsp outputs stable, req_ready 0, new req_valid ignored.
REQ-037 Assert rst in DEC -> rsp_valid never rises, err_count 0, next read works normally.
REQ-038 256 erroneous reads -> err_count saturates at 255.
